// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the divided-clock tick monitor.
package clk_tick_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned GOOD_W = 2;

  // Consecutive good intervals required in ACQ before declaring lock
  localparam logic [GOOD_W-1:0] LOCK_THRESH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } chan_state_e;

  // Saturating increment for the interval counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One monitored clock channel: synchronizer, edge detect, interval counter,
// lock FSM and sticky fault bit.
module tick_channel
  import clk_tick_pkg::*;
#(
  parameter int unsigned period = 100000,
  parameter int unsigned tol    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic clr_fault,
  output logic tick,
  output logic locked,
  output logic fault
);

  // Acceptance window; upper bound clamps instead of wrapping
  localparam logic [CNT_W:0]   HI_WIDE = (CNT_W+1)'(period) + (CNT_W+1)'(tol);
  localparam logic [CNT_W-1:0] HI      = HI_WIDE[CNT_W] ? '1 : HI_WIDE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] LO      = (period > tol) ? CNT_W'(period - tol) : '0;

  logic              sync1, sync2, hist;
  logic [2:0]        prime;
  logic [CNT_W-1:0]  cnt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  chan_state_e       state, state_nxt;
  logic              rise_c, good_c, timeout_c, fault_set_c, locked_nxt;

  // prime keeps a level that was already high at reset release from looking like an edge
  assign rise_c    = sync2 & ~hist & prime[2];
  assign good_c    = (cnt >= LO) && (cnt <= HI);
  assign timeout_c = !rise_c && (cnt > HI);

  // Synchronizer, history flop and registered tick pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      prime <= 3'b000;
      tick  <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      hist  <= sync2;
      prime <= {prime[1:0], 1'b1};
      tick  <= rise_c;
    end
  end

  // Interval counter: restarts at 1 on each tick, otherwise saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= rise_c ? CNT_W'(1) : sat_inc(cnt);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          state_nxt = ST_ACQ;
          good_nxt  = '0;
        end
      end
      ST_ACQ: begin
        if (rise_c) begin
          if (good_c) begin
            good_nxt = GOOD_W'(good_cnt + GOOD_W'(1));
            if (GOOD_W'(good_cnt + GOOD_W'(1)) >= LOCK_THRESH) state_nxt = ST_LOCKED;
          end else begin
            good_nxt = '0;
          end
        end else if (timeout_c) begin
          state_nxt = ST_IDLE;
          good_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if ((rise_c && !good_c) || timeout_c) state_nxt = ST_LOST;
      end
      ST_LOST: begin
        if (rise_c) begin
          state_nxt = ST_ACQ;
          good_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: lock status and loss-of-lock event
  always_comb begin
    locked_nxt  = (state_nxt == ST_LOCKED);
    fault_set_c = (state == ST_LOCKED) && ((rise_c && !good_c) || timeout_c);
  end

  // Registered outputs; a new fault beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      fault  <= 1'b0;
    end else begin
      locked <= locked_nxt;
      if (fault_set_c)    fault <= 1'b1;
      else if (clr_fault) fault <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_tick_monitor.sv
// Monitors three divided clocks (ms, 20ms, s) for lock against nominal periods.
module clk_tick_monitor
  import clk_tick_pkg::*;
#(
  parameter int unsigned period_ms   = 100000,
  parameter int unsigned period_20ms = 2000000,
  parameter int unsigned period_s    = 100000000,
  parameter int unsigned tol         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ms_in,
  input  logic       clk_20ms_in,
  input  logic       clk_s_in,
  input  logic       clr_fault,
  output logic       tick_ms,
  output logic       tick_20ms,
  output logic       tick_s,
  output logic [2:0] locked,
  output logic [2:0] fault
);

  tick_channel #(.period(period_ms), .tol(tol)) u_ch_ms (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_in    (clk_ms_in),
    .clr_fault (clr_fault),
    .tick      (tick_ms),
    .locked    (locked[0]),
    .fault     (fault[0])
  );

  tick_channel #(.period(period_20ms), .tol(tol)) u_ch_20ms (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_in    (clk_20ms_in),
    .clr_fault (clr_fault),
    .tick      (tick_20ms),
    .locked    (locked[1]),
    .fault     (fault[1])
  );

  tick_channel #(.period(period_s), .tol(tol)) u_ch_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_in    (clk_s_in),
    .clr_fault (clr_fault),
    .tick      (tick_s),
    .locked    (locked[2]),
    .fault     (fault[2])
  );

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Self-checking bench for clk_tick_monitor against a cycle-level behavioural model.
module tb_clk_tick_monitor;

  localparam int P_MS = 10;
  localparam int P_20 = 40;
  localparam int P_S  = 100;
  localparam int TOL  = 1;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_LOCKED = 2;
  localparam int M_LOST   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_fault = 1'b0;
  logic [2:0] din = 3'b000;
  logic       clk_ms_in, clk_20ms_in, clk_s_in;
  logic       tick_ms, tick_20ms, tick_s;
  logic [2:0] locked, fault;

  int total = 0;
  int bad   = 0;

  assign clk_ms_in   = din[0];
  assign clk_20ms_in = din[1];
  assign clk_s_in    = din[2];

  always #5 clk = ~clk;

  clk_tick_monitor #(
    .period_ms   (P_MS),
    .period_20ms (P_20),
    .period_s    (P_S),
    .tol         (TOL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_ms_in   (clk_ms_in),
    .clk_20ms_in (clk_20ms_in),
    .clk_s_in    (clk_s_in),
    .clr_fault   (clr_fault),
    .tick_ms     (tick_ms),
    .tick_20ms   (tick_20ms),
    .tick_s      (tick_s),
    .locked      (locked),
    .fault       (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-edge view of each channel
  int period_of [3] = '{P_MS, P_20, P_S};
  int m_edge;
  int m_state [3];
  int m_good  [3];
  int m_last  [3];
  bit m_fault [3];
  bit m_tick  [3];
  bit h1 [3];
  bit h2 [3];
  bit h3 [3];

  task automatic model_reset();
    m_edge = 0;
    for (int c = 0; c < 3; c++) begin
      m_state[c] = M_IDLE;
      m_good[c]  = 0;
      m_last[c]  = 1;
      m_fault[c] = 1'b0;
      m_tick[c]  = 1'b0;
      h1[c] = 1'b0; h2[c] = 1'b0; h3[c] = 1'b0;
    end
  endtask

  // A rising input first seen at edge n-2 (after low at n-3) yields a tick at edge n
  task automatic model_edge();
    m_edge++;
    for (int c = 0; c < 3; c++) begin
      bit rise, good, set;
      int cnt, lo, hi;
      rise = (m_edge >= 4) && h2[c] && !h3[c];
      cnt  = m_edge - m_last[c];
      lo   = (period_of[c] > TOL) ? period_of[c] - TOL : 0;
      hi   = period_of[c] + TOL;
      good = (cnt >= lo) && (cnt <= hi);
      set  = 1'b0;
      if (rise) begin
        case (m_state[c])
          M_IDLE, M_LOST: begin m_state[c] = M_ACQ; m_good[c] = 0; end
          M_ACQ: begin
            if (good) begin
              m_good[c]++;
              if (m_good[c] >= 2) m_state[c] = M_LOCKED;
            end else m_good[c] = 0;
          end
          default: if (!good) begin m_state[c] = M_LOST; set = 1'b1; end
        endcase
        m_last[c] = m_edge;
      end else if (cnt > hi) begin
        if (m_state[c] == M_ACQ) begin m_state[c] = M_IDLE; m_good[c] = 0; end
        else if (m_state[c] == M_LOCKED) begin m_state[c] = M_LOST; set = 1'b1; end
      end
      if (set) m_fault[c] = 1'b1;
      else if (clr_fault) m_fault[c] = 1'b0;
      m_tick[c] = rise;
      h3[c] = h2[c]; h2[c] = h1[c]; h1[c] = din[c];
    end
  endtask

  // Input waveform generator
  bit d_lvl  [3];
  int d_rem  [3];
  int d_lowp [3];
  bit d_hold [3];
  int d_jit  [3];
  int ms_ovr [$];

  function automatic int pick_period(input int c);
    if (c == 0 && ms_ovr.size() > 0) return ms_ovr.pop_front();
    return period_of[c] - d_jit[c] + int'($urandom_range(0, 2 * d_jit[c]));
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < 3; c++) begin
      if (d_hold[c]) begin
        d_lvl[c] = 1'b0;
        d_rem[c] = 0;
      end else if (d_rem[c] <= 1) begin
        if (!d_lvl[c]) begin
          int p;
          p = pick_period(c);
          d_lvl[c]  = 1'b1;
          d_rem[c]  = p / 2;
          d_lowp[c] = p - p / 2;
        end else begin
          d_lvl[c] = 1'b0;
          d_rem[c] = d_lowp[c];
        end
      end else begin
        d_rem[c]--;
      end
    end
    din = {d_lvl[2], d_lvl[1], d_lvl[0]};
  endtask

  // One clock: update model at the edge, compare at the falling edge, then drive
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("tick",   {29'd0, tick_s, tick_20ms, tick_ms}, {29'd0, m_tick[2], m_tick[1], m_tick[0]});
    check("locked", {29'd0, locked}, {29'd0, m_state[2] == M_LOCKED, m_state[1] == M_LOCKED, m_state[0] == M_LOCKED});
    check("fault",  {29'd0, fault},  {29'd0, m_fault[2], m_fault[1], m_fault[0]});
    clr_fault = 1'b0;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int nt;
    for (int c = 0; c < 3; c++) begin
      d_lvl[c] = 1'b0; d_rem[c] = 0; d_lowp[c] = 0; d_hold[c] = 1'b0; d_jit[c] = 0;
    end
    model_reset();

    // Reset state
    #12;
    check("rst_tick",   {29'd0, tick_s, tick_20ms, tick_ms}, 32'd0);
    check("rst_locked", {29'd0, locked}, 32'd0);
    check("rst_fault",  {29'd0, fault},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_inputs();

    // Nominal periods on all channels
    run(500);
    check("all_locked", {29'd0, locked}, 32'd7);
    check("no_fault",   {29'd0, fault},  32'd0);
    nt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      nt += int'(tick_ms);
    end
    check("ms_tick_rate", nt, 3);

    // One stretched ms period, then relock with sticky fault
    ms_ovr.push_back(12);
    run(30);
    check("stretch_fault",    {31'd0, fault[0]},  32'd1);
    check("stretch_unlocked", {31'd0, locked[0]}, 32'd0);
    run(45);
    check("relock_ms",        {31'd0, locked[0]}, 32'd1);
    check("fault_sticky",     {31'd0, fault[0]},  32'd1);

    // In-tolerance jitter keeps lock, interval of 8 breaks it
    clr_fault = 1'b1;
    step();
    check("clr_ms_fault", {31'd0, fault[0]}, 32'd0);
    ms_ovr.push_back(9); ms_ovr.push_back(11); ms_ovr.push_back(10);
    run(50);
    check("jitter_locked", {31'd0, locked[0]}, 32'd1);
    check("jitter_nofault", {31'd0, fault[0]}, 32'd0);
    ms_ovr.push_back(8);
    run(30);
    check("short_fault", {31'd0, fault[0]}, 32'd1);

    // 20ms held low: timeout, with clear colliding on the setting edge
    d_hold[1] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (m_state[1] == M_LOCKED && (m_edge + 1 - m_last[1]) == P_20 + TOL + 1) clr_fault = 1'b1;
      step();
    end
    check("timeout_fault",  {31'd0, fault[1]},  32'd1);
    check("timeout_unlock", {31'd0, locked[1]}, 32'd0);
    clr_fault = 1'b1;
    step();
    check("timeout_clr", {31'd0, fault[1]}, 32'd0);
    d_hold[1] = 1'b0;

    // Randomized jitter, stalls and clears
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0)
        for (int c = 0; c < 3; c++) d_jit[c] = int'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        int c;
        c = int'($urandom_range(0, 2));
        d_hold[c] = !d_hold[c];
      end
      clr_fault = ($urandom_range(0, 49) == 0);
      step();
    end

    // Back to nominal, then asynchronous reset with ms input high
    for (int c = 0; c < 3; c++) begin d_jit[c] = 0; d_hold[c] = 1'b0; end
    clr_fault = 1'b1;
    run(450);
    check("relock_all", {29'd0, locked}, 32'd7);
    for (int i = 0; i < 20 && !din[0]; i++) step();
    check("ms_high_before_rst", {31'd0, din[0]}, 32'd1);
    d_rem[0] = 5;
    #2 rst_n = 1'b0;
    #1;
    check("arst_tick",   {29'd0, tick_s, tick_20ms, tick_ms}, 32'd0);
    check("arst_locked", {29'd0, locked}, 32'd0);
    check("arst_fault",  {29'd0, fault},  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    nt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nt += int'(tick_ms);
    end
    check("no_tick_high_at_release", nt, 0);
    run(450);
    check("relock_after_rst", {29'd0, locked}, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
